// File: rtl/miner_result_queue.sv
// Show-ahead queue of golden nonces from the miner core, flushed on every new block.
// Optional MINER_RESULT_TIMESTAMP_EN adds a per-entry cycle count since the block was loaded.
module miner_result_queue #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_main_a0,
    input  logic          rst_main_n,
    input  logic          new_block,
    input  logic          nonce_found,
    input  logic [31:0]   nonce_in,
    input  logic          pop,
    output logic [31:0]   head_nonce,
    output logic [31:0]   head_cycles,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow
);

`ifdef MINER_RESULT_TIMESTAMP_EN
    localparam int EW = 64;
`else
    localparam int EW = 32;
`endif

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(1'b0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(1'b0);

    logic [EW-1:0]  mem_r [DEPTH];

    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [AW:0]    count_r;
    logic           empty_r;
    logic           overflow_r;
    logic [31:0]    last_nonce_r;
    logic           last_vld_r;

    logic [AW-1:0]  wr_ptr_s;
    logic [AW-1:0]  rd_ptr_s;
    logic [AW:0]    count_s;
    logic           empty_s;
    logic           overflow_s;
    logic [31:0]    last_nonce_s;
    logic           last_vld_s;

    logic           dup_s;
    logic           cand_s;
    logic           full_s;
    logic           pop_ok_s;
    logic           push_ok_s;
    logic [EW-1:0]  entry_s;
    logic [EW-1:0]  head_entry_s;

    // A repeat of the last reported nonce is the miner re-reporting the same hit.
    assign dup_s     = last_vld_r && (nonce_in == last_nonce_r);
    // Anything arriving with new_block belongs to the previous block and is discarded.
    assign cand_s    = nonce_found && !dup_s && !new_block;
    assign full_s    = (count_r == CNT_FULL);
    assign pop_ok_s  = pop && !empty_r && !new_block;
    assign push_ok_s = cand_s && (!full_s || pop_ok_s);

`ifdef MINER_RESULT_TIMESTAMP_EN
    logic [31:0] elapsed_r;

    // Block timer: restarts on new_block and saturates instead of wrapping.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            elapsed_r <= 32'h0000_0000;
        end else if (new_block) begin
            elapsed_r <= 32'h0000_0000;
        end else if (elapsed_r != 32'hFFFF_FFFF) begin
            elapsed_r <= elapsed_r + 32'h0000_0001;
        end else begin
            elapsed_r <= elapsed_r;
        end
    end

    assign entry_s = {nonce_in, elapsed_r};
`else
    assign entry_s = nonce_in;
`endif

    // Next-state computation for pointers, occupancy and duplicate filter.
    always_comb begin
        wr_ptr_s     = wr_ptr_r;
        rd_ptr_s     = rd_ptr_r;
        count_s      = count_r;
        overflow_s   = overflow_r;
        last_nonce_s = last_nonce_r;
        last_vld_s   = last_vld_r;

        if (new_block) begin
            wr_ptr_s   = PTR_ZERO;
            rd_ptr_s   = PTR_ZERO;
            count_s    = CNT_ZERO;
            overflow_s = 1'b0;
            last_vld_s = 1'b0;
        end else begin
            if (cand_s) begin
                last_nonce_s = nonce_in;
                last_vld_s   = 1'b1;
            end else begin
                last_nonce_s = last_nonce_r;
                last_vld_s   = last_vld_r;
            end

            if (push_ok_s) begin
                wr_ptr_s = wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_s = wr_ptr_r;
            end

            if (pop_ok_s) begin
                rd_ptr_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_s = rd_ptr_r;
            end

            if (cand_s && !push_ok_s) begin
                overflow_s = 1'b1;
            end else begin
                overflow_s = overflow_r;
            end

            case ({push_ok_s, pop_ok_s})
                2'b10:   count_s = count_r + CNT_ONE;
                2'b01:   count_s = count_r - CNT_ONE;
                default: count_s = count_r;
            endcase
        end

        empty_s = (count_s == CNT_ZERO);
    end

    // Control state register.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            wr_ptr_r     <= PTR_ZERO;
            rd_ptr_r     <= PTR_ZERO;
            count_r      <= CNT_ZERO;
            empty_r      <= 1'b1;
            overflow_r   <= 1'b0;
            last_nonce_r <= 32'h0000_0000;
            last_vld_r   <= 1'b0;
        end else begin
            wr_ptr_r     <= wr_ptr_s;
            rd_ptr_r     <= rd_ptr_s;
            count_r      <= count_s;
            empty_r      <= empty_s;
            overflow_r   <= overflow_s;
            last_nonce_r <= last_nonce_s;
            last_vld_r   <= last_vld_s;
        end
    end

    // Entry storage; contents are qualified by count so they need no reset.
    always_ff @(posedge clk_main_a0) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= entry_s;
        end
    end

    assign head_entry_s = mem_r[rd_ptr_r];

    // Head presentation, forced to zero while the queue is empty.
    always_comb begin
        head_nonce  = 32'h0000_0000;
        head_cycles = 32'h0000_0000;
        if (empty_r) begin
            head_nonce  = 32'h0000_0000;
            head_cycles = 32'h0000_0000;
        end else begin
            head_nonce  = head_entry_s[EW-1 -: 32];
`ifdef MINER_RESULT_TIMESTAMP_EN
            head_cycles = head_entry_s[31:0];
`else
            head_cycles = 32'h0000_0000;
`endif
        end
    end

    assign count    = count_r;
    assign empty    = empty_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_miner_result_queue.sv
// Directed self-checking bench for miner_result_queue (DEPTH=16).
module tb_miner_result_queue;

    logic        clk_main_a0;
    logic        rst_main_n;
    logic        new_block;
    logic        nonce_found;
    logic [31:0] nonce_in;
    logic        pop;
    logic [31:0] head_nonce;
    logic [31:0] head_cycles;
    logic        empty;
    logic [4:0]  count;
    logic        overflow;

    int n_cmp;
    int n_err;

`ifdef MINER_RESULT_TIMESTAMP_EN
    localparam logic [31:0] EXP_TS9 = 32'd9;
`else
    localparam logic [31:0] EXP_TS9 = 32'd0;
`endif

    miner_result_queue #(.DEPTH(16)) dut (
        .clk_main_a0 (clk_main_a0),
        .rst_main_n  (rst_main_n),
        .new_block   (new_block),
        .nonce_found (nonce_found),
        .nonce_in    (nonce_in),
        .pop         (pop),
        .head_nonce  (head_nonce),
        .head_cycles (head_cycles),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow)
    );

    initial clk_main_a0 = 1'b0;
    always #5 clk_main_a0 = ~clk_main_a0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_main_a0);
        #1;
    endtask

    task automatic push1(input logic [31:0] v);
        nonce_found = 1'b1;
        nonce_in    = v;
        tick();
        nonce_found = 1'b0;
    endtask

    task automatic pop1();
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic flush();
        new_block = 1'b1;
        tick();
        new_block = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_main_n  = 1'b0;
        new_block   = 1'b0;
        nonce_found = 1'b0;
        nonce_in    = 32'h0;
        pop         = 1'b0;
        repeat (3) tick();

        // 1. reset state
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_hnonce", head_nonce, 32'h0);
        chk("rst_hcyc", head_cycles, 32'h0);
        rst_main_n = 1'b1;
        tick();

        // 2. timestamp and pop
        flush();
        repeat (9) tick();
        push1(32'h1234_5678);
        chk("ts_hnonce", head_nonce, 32'h1234_5678);
        chk("ts_hcyc", head_cycles, EXP_TS9);
        chk("ts_count", 32'(count), 32'd1);
        pop1();
        chk("ts_pop_empty", 32'(empty), 32'd1);
        chk("ts_pop_hnonce", head_nonce, 32'h0);

        // 3. duplicate suppression
        nonce_found = 1'b1;
        nonce_in = 32'hAAAA_0001;
        repeat (5) tick();
        nonce_in = 32'hAAAA_0002;
        tick();
        nonce_in = 32'hAAAA_0001;
        tick();
        nonce_found = 1'b0;
        chk("dup_count", 32'(count), 32'd3);
        chk("dup_h0", head_nonce, 32'hAAAA_0001);
        pop1();
        chk("dup_h1", head_nonce, 32'hAAAA_0002);
        pop1();
        chk("dup_h2", head_nonce, 32'hAAAA_0001);
        pop1();
        chk("dup_empty", 32'(empty), 32'd1);

        // 4. full and overflow
        for (int i = 0; i < 16; i++) push1(32'h1000_0000 + 32'(i));
        chk("full_count", 32'(count), 32'd16);
        chk("full_ovf0", 32'(overflow), 32'd0);
        push1(32'h1000_0010);
        chk("ovf_count", 32'(count), 32'd16);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_head", head_nonce, 32'h1000_0000);
        tick();
        pop = 1'b1;
        push1(32'h1000_0011);
        pop = 1'b0;
        chk("fullpp_count", 32'(count), 32'd16);
        chk("fullpp_head", head_nonce, 32'h1000_0001);
        for (int i = 1; i < 16; i++) begin
            chk("drain_order", head_nonce, 32'h1000_0000 + 32'(i));
            pop1();
        end
        chk("drain_last", head_nonce, 32'h1000_0011);
        pop1();
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_ovf_sticky", 32'(overflow), 32'd1);

        // 5. pointer wrap
        flush();
        for (int i = 0; i < 40; i++) begin
            push1(32'h2000_0000 + 32'(i));
            chk("wrap_count1", 32'(count), 32'd1);
            chk("wrap_head", head_nonce, 32'h2000_0000 + 32'(i));
            pop1();
            chk("wrap_count0", 32'(count), 32'd0);
        end
        chk("wrap_ovf", 32'(overflow), 32'd0);

        // 6. new_block priority
        for (int i = 0; i < 17; i++) push1(32'h3000_0000 + 32'(i));
        repeat (13) pop1();
        chk("pri_pre_count", 32'(count), 32'd3);
        chk("pri_pre_ovf", 32'(overflow), 32'd1);
        chk("pri_pre_head", head_nonce, 32'h3000_000D);
        new_block   = 1'b1;
        nonce_found = 1'b1;
        nonce_in    = 32'hDEAD_BEEF;
        pop         = 1'b1;
        tick();
        new_block   = 1'b0;
        nonce_found = 1'b0;
        pop         = 1'b0;
        chk("pri_empty", 32'(empty), 32'd1);
        chk("pri_ovf", 32'(overflow), 32'd0);
        chk("pri_hnonce", head_nonce, 32'h0);
        chk("pri_count", 32'(count), 32'd0);
        push1(32'hDEAD_BEEF);
        chk("pri_accept_count", 32'(count), 32'd1);
        chk("pri_accept_head", head_nonce, 32'hDEAD_BEEF);
        chk("pri_accept_hcyc", head_cycles, 32'd0);

        // mid-operation asynchronous reset
        #2;
        rst_main_n = 1'b0;
        #1;
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_hnonce", head_nonce, 32'h0);
        tick();
        rst_main_n = 1'b1;
        tick();

        // pop on empty is ignored; push+pop on empty accepts the push
        pop1();
        chk("epop_count", 32'(count), 32'd0);
        chk("epop_ovf", 32'(overflow), 32'd0);
        pop = 1'b1;
        push1(32'h4000_0001);
        pop = 1'b0;
        chk("epp_count", 32'(count), 32'd1);
        chk("epp_head", head_nonce, 32'h4000_0001);
        // push and pop with one entry held keeps count
        pop = 1'b1;
        push1(32'h4000_0002);
        pop = 1'b0;
        chk("pp_count", 32'(count), 32'd1);
        chk("pp_head", head_nonce, 32'h4000_0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
